sseg_scan_driver: RTL and testbench

// - Parametrised N-digit multiplexed 7-segment driver; successor to the fixed 4-digit display path.
// - Converts a binary value to BCD sequentially (double-dabble, one bit per clk).
// - Adds the following, then scans the digits onto shared segment lines:
//   - leading-zero blanking
//   - programmable decimal-point position
//   - overflow indication
//   - 16-level PWM brightness
// - Sits between the stopwatch/counter datapath and the board's 7-seg pins.
//

---
 rtl/sseg_pkg.sv | 49 ++++
 rtl/bin2bcd_seq.sv | 73 +++++++
 rtl/sseg_scan_driver.sv | 167 ++++++++++++++++
 tb/tb_sseg_scan_driver.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sseg_pkg.sv
// Shared segment encodings and sizing helpers for the multiplexed 7-segment driver.
// Segment bit order is {g,f,e,d,c,b,a}, active-high before any polarity inversion.
package sseg_pkg;

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_BLANK = 7'h00;
    localparam logic [6:0] SEG_DASH  = 7'h40;

    function automatic int bcd_w(input int n_digits);
        return 4 * n_digits;
    endfunction

    function automatic longint unsigned pow10(input int n);
        longint unsigned r;
        r = 1;
        for (int i = 0; i < n; i++) begin
            r = r * 10;
        end
        return r;
    endfunction

    function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = SEG_0;
            4'd1:    s = SEG_1;
            4'd2:    s = SEG_2;
            4'd3:    s = SEG_3;
            4'd4:    s = SEG_4;
            4'd5:    s = SEG_5;
            4'd6:    s = SEG_6;
            4'd7:    s = SEG_7;
            4'd8:    s = SEG_8;
            4'd9:    s = SEG_9;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: one input bit per clk, then a single commit cycle flagged by o_done.
// The BCD register holds only N_DIGITS digits; out-of-range inputs are caught at latch time.
module bin2bcd_seq
    import sseg_pkg::*;
#(
    parameter int BIN_WIDTH = 16,
    parameter int N_DIGITS  = 4,
    localparam int BCD_W    = bcd_w(N_DIGITS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_start,
    input  logic [BIN_WIDTH-1:0] i_bin,
    output logic [BCD_W-1:0]     o_bcd,
    output logic                 o_ovf,
    output logic                 o_done,
    output logic                 o_busy
);

    localparam int CNT_W = $clog2(BIN_WIDTH + 1);
    localparam longint unsigned MAX_VAL = pow10(N_DIGITS) - 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_WIDTH);

    logic [BIN_WIDTH-1:0] bin_reg;
    logic [BCD_W-1:0]     bcd_reg;
    logic [BCD_W-1:0]     bcd_adj;
    logic [BCD_W-1:0]     bcd_next;
    logic [CNT_W-1:0]     cnt_reg;
    logic                 busy_reg;
    logic                 ovf_reg;
    logic                 shifting;

    generate
        for (genvar gi = 0; gi < N_DIGITS; gi++) begin : g_adj
            assign bcd_adj[gi*4 +: 4] = (bcd_reg[gi*4 +: 4] >= 4'd5) ?
                                        bcd_reg[gi*4 +: 4] + 4'd3 : bcd_reg[gi*4 +: 4];
        end
    endgenerate

    // Carries out of the top digit are dropped; lower digits stay exact (value mod 10^N).
    assign bcd_next = (bcd_adj << 1) | BCD_W'(bin_reg[BIN_WIDTH-1]);
    assign shifting = busy_reg && (cnt_reg != LAST_CNT);

    always_ff @(posedge clk) begin
        if (rst) begin
            bin_reg  <= '0;
            bcd_reg  <= '0;
            cnt_reg  <= '0;
            busy_reg <= 1'b0;
            ovf_reg  <= 1'b0;
        end else if (!busy_reg) begin
            if (i_start) begin
                bin_reg  <= i_bin;
                bcd_reg  <= '0;
                cnt_reg  <= '0;
                busy_reg <= 1'b1;
                ovf_reg  <= 64'(i_bin) > MAX_VAL;
            end
        end else if (shifting) begin
            bin_reg <= bin_reg << 1;
            bcd_reg <= bcd_next;
            cnt_reg <= cnt_reg + 1'b1;
        end else begin
            busy_reg <= 1'b0;
        end
    end

    assign o_bcd  = bcd_reg;
    assign o_ovf  = ovf_reg;
    assign o_done = busy_reg && (cnt_reg == LAST_CNT);
    assign o_busy = busy_reg;

endmodule

// File: rtl/sseg_scan_driver.sv
// N-digit multiplexed 7-segment driver: queued BCD conversion, leading-zero blanking,
// decimal point, overflow dashes and 16-level PWM brightness on shared segment lines.
module sseg_scan_driver
    import sseg_pkg::*;
#(
    parameter int N_DIGITS         = 4,
    parameter int BIN_WIDTH        = 16,
    parameter int PWM_STEP         = 3125,
    parameter int ANODE_ACTIVE_LOW = 1,
    parameter int SEG_ACTIVE_LOW   = 1,
    localparam int DP_W            = $clog2(N_DIGITS + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [BIN_WIDTH-1:0] i_num,
    input  logic                 i_load,
    input  logic [DP_W-1:0]      i_dp_pos,
    input  logic                 i_blank_lz,
    input  logic [3:0]           i_bright,
    output logic [6:0]           o_sseg,
    output logic                 o_dp,
    output logic [N_DIGITS-1:0]  o_seg_an,
    output logic                 o_busy
);

    localparam int BCD_W  = bcd_w(N_DIGITS);
    localparam int IDX_W  = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int STEP_W = (PWM_STEP > 1) ? $clog2(PWM_STEP) : 1;
    localparam logic AN_INV  = (ANODE_ACTIVE_LOW != 0);
    localparam logic SEG_INV = (SEG_ACTIVE_LOW != 0);

    logic [BCD_W-1:0] conv_bcd;
    logic             conv_ovf;
    logic             conv_done;
    logic             conv_busy;
    logic             conv_start;
    logic             pending_reg;

    logic [BCD_W-1:0] disp_bcd_reg;
    logic             disp_dash_reg;

    // A load arriving while busy (commit cycle included) is remembered and replayed once idle.
    assign conv_start = !conv_busy && (i_load || pending_reg);

    bin2bcd_seq #(
        .BIN_WIDTH (BIN_WIDTH),
        .N_DIGITS  (N_DIGITS)
    ) u_bin2bcd (
        .clk     (clk),
        .rst     (rst),
        .i_start (conv_start),
        .i_bin   (i_num),
        .o_bcd   (conv_bcd),
        .o_ovf   (conv_ovf),
        .o_done  (conv_done),
        .o_busy  (conv_busy)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            pending_reg <= 1'b0;
        end else if (conv_busy && i_load) begin
            pending_reg <= 1'b1;
        end else if (conv_start) begin
            pending_reg <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            disp_bcd_reg  <= '0;
            disp_dash_reg <= 1'b0;
        end else if (conv_done) begin
            disp_bcd_reg  <= conv_bcd;
            disp_dash_reg <= conv_ovf;
        end
    end

    logic [3:0]          disp_digit [N_DIGITS];
    logic [N_DIGITS-1:0] digit_zero;
    logic [N_DIGITS-1:0] zero_above;
    logic [N_DIGITS-1:0] blank;
    logic                dp_none;

    assign dp_none = int'(i_dp_pos) >= N_DIGITS;

    // zero_above[k]: digits k..N-1 are all zero (never true while showing dashes).
    generate
        for (genvar gi = 0; gi < N_DIGITS; gi++) begin : g_digit
            assign disp_digit[gi] = disp_bcd_reg[gi*4 +: 4];
            assign digit_zero[gi] = !disp_dash_reg && (disp_bcd_reg[gi*4 +: 4] == 4'd0);
            if (gi == N_DIGITS - 1) begin : g_top
                assign zero_above[gi] = digit_zero[gi];
            end else begin : g_mid
                assign zero_above[gi] = digit_zero[gi] && zero_above[gi+1];
            end
            if (gi == 0) begin : g_units
                assign blank[gi] = 1'b0;
            end else begin : g_upper
                assign blank[gi] = i_blank_lz && zero_above[gi] &&
                                   (dp_none || (gi > int'(i_dp_pos)));
            end
        end
    endgenerate

    logic [STEP_W-1:0] step_reg;
    logic [3:0]        sub_reg;
    logic [IDX_W-1:0]  idx_reg;
    logic [3:0]        bright_reg;
    logic [3:0]        bright_eff;
    logic              step_last;

    // Brightness is sampled on the first clk of each sub-step and held for the rest of it.
    assign bright_eff = (step_reg == '0) ? i_bright : bright_reg;
    assign step_last  = (step_reg == STEP_W'(PWM_STEP - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            step_reg   <= '0;
            sub_reg    <= '0;
            idx_reg    <= '0;
            bright_reg <= '0;
        end else begin
            bright_reg <= bright_eff;
            if (step_last) begin
                step_reg <= '0;
                sub_reg  <= sub_reg + 1'b1;
                if (sub_reg == 4'd15) begin
                    idx_reg <= (idx_reg == IDX_W'(N_DIGITS - 1)) ? '0 : idx_reg + 1'b1;
                end
            end else begin
                step_reg <= step_reg + 1'b1;
            end
        end
    end

    logic [6:0]          seg_raw;
    logic                dp_on;
    logic [N_DIGITS-1:0] an_vec;

    always_comb begin
        seg_raw = bcd_to_seg(disp_digit[idx_reg]);
        if (disp_dash_reg) begin
            seg_raw = SEG_DASH;
        end else if (blank[idx_reg]) begin
            seg_raw = SEG_BLANK;
        end
    end

    assign dp_on  = (int'(i_dp_pos) == int'(idx_reg));
    assign an_vec = (sub_reg < bright_eff) ? (N_DIGITS'(1) << idx_reg) : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            o_seg_an <= {N_DIGITS{AN_INV}};
            o_sseg   <= {7{SEG_INV}};
            o_dp     <= SEG_INV;
        end else begin
            o_seg_an <= an_vec ^ {N_DIGITS{AN_INV}};
            o_sseg   <= seg_raw ^ {7{SEG_INV}};
            o_dp     <= dp_on ^ SEG_INV;
        end
    end

    assign o_busy = conv_busy;

endmodule

// File: tb/tb_sseg_scan_driver.sv
// Bench for sseg_scan_driver (4 digits, PWM_STEP=2, active-low): digit table, hand-written
// corner sequences, and a random phase scored cycle-by-cycle against an arithmetic model.
module tb_sseg_scan_driver;

    localparam int N_DIGITS  = 4;
    localparam int BIN_WIDTH = 16;
    localparam int PWM_STEP  = 2;
    localparam int SLOT      = 16 * PWM_STEP;
    localparam int SCAN      = N_DIGITS * SLOT;
    localparam int NV        = 10;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] i_num = '0;
    logic        i_load = 1'b0;
    logic [2:0]  i_dp_pos = 3'd4;
    logic        i_blank_lz = 1'b0;
    logic [3:0]  i_bright = 4'd15;
    logic [6:0]  o_sseg;
    logic        o_dp;
    logic [3:0]  o_seg_an;
    logic        o_busy;

    int n_cmp = 0;
    int n_bad = 0;
    int n_print = 0;

    always #5 clk = ~clk;

    sseg_scan_driver #(
        .N_DIGITS         (N_DIGITS),
        .BIN_WIDTH        (BIN_WIDTH),
        .PWM_STEP         (PWM_STEP),
        .ANODE_ACTIVE_LOW (1),
        .SEG_ACTIVE_LOW   (1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .i_num      (i_num),
        .i_load     (i_load),
        .i_dp_pos   (i_dp_pos),
        .i_blank_lz (i_blank_lz),
        .i_bright   (i_bright),
        .o_sseg     (o_sseg),
        .o_dp       (o_dp),
        .o_seg_an   (o_seg_an),
        .o_busy     (o_busy)
    );

    // ---------------- reference model ----------------
    int p10 [0:4] = '{1, 10, 100, 1000, 10000};

    function automatic logic [6:0] dig_code(input int d);
        case (d)
            0: return 7'h3F;  1: return 7'h06;  2: return 7'h5B;  3: return 7'h4F;
            4: return 7'h66;  5: return 7'h6D;  6: return 7'h7D;  7: return 7'h07;
            8: return 7'h7F;  9: return 7'h6F;
            default: return 7'h00;
        endcase
    endfunction

    int          m_pos, m_hold, m_cnt;
    bit          m_busy, m_pend, model_ok = 1'b0;
    int unsigned m_val, m_disp;
    logic [3:0]  exp_an;
    logic [6:0]  exp_seg;
    logic        exp_dp, exp_busy;

    function automatic logic [6:0] model_seg(input int idx);
        if (m_disp > 9999) return 7'h40;
        if (i_blank_lz && idx > 0 && (m_disp / p10[idx]) == 0 && (i_dp_pos >= 4 || idx > i_dp_pos))
            return 7'h00;
        return dig_code(int'((m_disp / p10[idx]) % 10));
    endfunction

    always @(posedge clk) begin
        int sub, idx;
        if (rst) begin
            m_pos = 0; m_hold = 0; m_cnt = 0; m_busy = 0; m_pend = 0; m_disp = 0;
            exp_an = 4'hF; exp_seg = 7'h7F; exp_dp = 1'b1; exp_busy = 1'b0;
            model_ok = 1'b1;
        end else begin
            sub = (m_pos / PWM_STEP) % 16;
            idx = (m_pos / SLOT) % N_DIGITS;
            if (m_pos % PWM_STEP == 0) m_hold = int'(i_bright);
            exp_an  = (sub < m_hold) ? ~(4'b0001 << idx) : 4'hF;
            exp_seg = ~model_seg(idx);
            exp_dp  = (int'(i_dp_pos) == idx) ? 1'b0 : 1'b1;
            m_pos++;
            if (m_busy) begin
                if (i_load) m_pend = 1;
                m_cnt++;
                if (m_cnt == BIN_WIDTH + 1) begin
                    m_busy = 0;
                    m_disp = m_val;
                end
            end else if (i_load || m_pend) begin
                m_val = i_num; m_busy = 1; m_cnt = 0; m_pend = 0;
            end
            exp_busy = m_busy;
        end
    end

    always @(negedge clk) begin
        if (model_ok) begin
            n_cmp++;
            if ({o_seg_an, o_sseg, o_dp, o_busy} !== {exp_an, exp_seg, exp_dp, exp_busy}) begin
                n_bad++;
                if (n_print < 20) begin
                    n_print++;
                    $display("FAIL scoreboard t=%0t got an=%b sseg=%h dp=%b busy=%b want an=%b sseg=%h dp=%b busy=%b",
                             $time, o_seg_an, o_sseg, o_dp, o_busy, exp_an, exp_seg, exp_dp, exp_busy);
                end
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic chk(input string nm, input int act, input int req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", nm, act, act, req, req);
        end else begin
            $display("check %s: %0d ok", nm, act);
        end
    endtask

    task automatic do_load(input int v);
        int k;
        k = 0;
        @(negedge clk); i_num = 16'(v); i_load = 1'b1;
        @(negedge clk); i_load = 1'b0;
        while (o_busy && k < 100) begin k++; @(negedge clk); end
        chk($sformatf("busy_len_%0d", v), k, 17);
    endtask

    logic [6:0] cap_seg [4];
    logic [3:0] cap_dp;
    int         cap_lit [4];
    int         cap_twohot;

    task automatic capture_scan();
        for (int d = 0; d < 4; d++) begin cap_seg[d] = 7'h55; cap_lit[d] = 0; end
        cap_dp = '0; cap_twohot = 0;
        repeat (SCAN) begin
            @(negedge clk);
            if ($countones(~o_seg_an) > 1) cap_twohot++;
            for (int d = 0; d < 4; d++) begin
                if (o_seg_an == ~(4'b0001 << d)) begin
                    cap_lit[d]++;
                    cap_seg[d] = ~o_sseg;
                    cap_dp[d]  = ~o_dp;
                end
            end
        end
    endtask

    task automatic chk_digits(input string nm, input logic [27:0] segs);
        logic [6:0] e;
        for (int d = 0; d < 4; d++) begin
            e = segs[d*7 +: 7];
            chk($sformatf("%s_seg%0d", nm, d), int'(cap_seg[d]), int'(e));
        end
    endtask

    typedef struct {
        int          num;
        bit          blz;
        int          dp;
        logic [27:0] segs;   // {d3,d2,d1,d0}, active-high codes
    } vec_t;

    vec_t vecs [NV];

    // ---------------- stimulus ----------------
    initial begin
        int k;
        int rises;
        int total;
        logic prev;

        vecs[0] = '{1234,  1'b0, 4, {7'h06, 7'h5B, 7'h4F, 7'h66}};
        vecs[1] = '{7,     1'b1, 2, {7'h00, 7'h3F, 7'h3F, 7'h07}};
        vecs[2] = '{7,     1'b1, 4, {7'h00, 7'h00, 7'h00, 7'h07}};
        vecs[3] = '{10000, 1'b0, 4, {7'h40, 7'h40, 7'h40, 7'h40}};
        vecs[4] = '{9999,  1'b0, 4, {7'h6F, 7'h6F, 7'h6F, 7'h6F}};
        vecs[5] = '{10000, 1'b1, 1, {7'h40, 7'h40, 7'h40, 7'h40}};
        vecs[6] = '{0,     1'b1, 4, {7'h00, 7'h00, 7'h00, 7'h3F}};
        vecs[7] = '{65535, 1'b0, 4, {7'h40, 7'h40, 7'h40, 7'h40}};
        vecs[8] = '{305,   1'b1, 0, {7'h00, 7'h4F, 7'h3F, 7'h6D}};
        vecs[9] = '{50,    1'b0, 3, {7'h3F, 7'h3F, 7'h6D, 7'h3F}};

        // reset, run into mid-scan, then reset again for 3 clks
        rst = 1'b1; repeat (3) @(negedge clk); rst = 1'b0;
        repeat (70) @(negedge clk);
        rst = 1'b1; repeat (3) @(negedge clk);
        chk("rst_an", int'(o_seg_an), 4'hF);
        chk("rst_sseg", int'(o_sseg), 7'h7F);
        chk("rst_busy", int'(o_busy), 0);
        rst = 1'b0;
        @(negedge clk);
        chk("first_an", int'(o_seg_an), 4'b1110);
        chk("first_sseg", int'(o_sseg), 7'h40);

        // digit table
        for (int v = 0; v < NV; v++) begin
            i_blank_lz = vecs[v].blz;
            i_dp_pos   = 3'(vecs[v].dp);
            do_load(vecs[v].num);
            capture_scan();
            chk_digits($sformatf("v%0d", v), vecs[v].segs);
            chk($sformatf("v%0d_dp", v), int'(cap_dp), (vecs[v].dp < 4) ? (1 << vecs[v].dp) : 0);
            total = 0;
            for (int d = 0; d < 4; d++) if (cap_lit[d] == 15 * PWM_STEP) total++;
            chk($sformatf("v%0d_duty_ok_digits", v), total, 4);
            chk($sformatf("v%0d_twohot", v), cap_twohot, 0);
        end

        // pending load: second conversion samples the changed i_num, third load merges
        i_blank_lz = 1'b0; i_dp_pos = 3'd4;
        @(negedge clk); i_num = 16'd99; i_load = 1'b1;
        @(negedge clk); i_load = 1'b0; i_num = 16'd42;
        repeat (4) @(negedge clk); i_load = 1'b1;
        @(negedge clk); i_load = 1'b0;
        repeat (5) @(negedge clk); i_load = 1'b1;
        @(negedge clk); i_load = 1'b0;
        k = 0;
        while (o_busy && k < 100) begin k++; @(negedge clk); end
        chk("pend_first_fell", int'(o_busy), 0);
        @(negedge clk);
        chk("pend_restart", int'(o_busy), 1);
        k = 0;
        while (o_busy && k < 100) begin k++; @(negedge clk); end
        chk("pend_busy_len", k, 17);
        rises = 0; prev = o_busy;
        repeat (40) begin @(negedge clk); if (o_busy && !prev) rises++; prev = o_busy; end
        chk("pend_no_third", rises, 0);
        capture_scan();
        chk_digits("pend_0042", {7'h3F, 7'h3F, 7'h66, 7'h5B});

        // brightness 0, then 15 -> 1 mid-slot
        i_bright = 4'd0;
        capture_scan();
        total = 0;
        for (int d = 0; d < 4; d++) total += cap_lit[d];
        chk("dark_lit_total", total, 0);
        i_bright = 4'd15;
        repeat (SLOT + 5) @(negedge clk);
        i_bright = 4'd1;
        repeat (SLOT) @(negedge clk);
        capture_scan();
        total = 0;
        for (int d = 0; d < 4; d++) if (cap_lit[d] == PWM_STEP) total++;
        chk("dim_duty_ok_digits", total, 4);
        i_bright = 4'd15;

        // reset mid-conversion leaves the display at zero
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        @(negedge clk); i_num = 16'd5555; i_load = 1'b1;
        @(negedge clk); i_load = 1'b0;
        repeat (5) @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        repeat (40) @(negedge clk);
        chk("rstconv_busy", int'(o_busy), 0);
        capture_scan();
        chk_digits("rstconv_0000", {7'h3F, 7'h3F, 7'h3F, 7'h3F});

        // random phase, scored by the model every cycle
        for (int c = 0; c < 2500; c++) begin
            @(negedge clk);
            rst    = ($urandom_range(0, 499) == 0);
            i_load = ($urandom_range(0, 15) == 0);
            if (i_load || $urandom_range(0, 7) == 0) begin
                case ($urandom_range(0, 3))
                    0:       i_num = 16'($urandom_range(0, 99));
                    1:       i_num = 16'($urandom_range(9990, 10010));
                    2:       i_num = 16'($urandom);
                    default: i_num = 16'($urandom_range(0, 9999));
                endcase
            end
            if ($urandom_range(0, 63) == 0) i_bright = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 99) == 0) begin
                i_blank_lz = 1'($urandom_range(0, 1));
                i_dp_pos   = 3'($urandom_range(0, 4));
            end
        end
        @(negedge clk); rst = 1'b0; i_load = 1'b0;
        repeat (2) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, compared=%0d", n_cmp);
        $fatal(1, "watchdog");
    end

endmodule
